// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one byte at a time from NUM_REQ sources into a
// shared UART TX top, holding TX_DATA for the whole frame and watching for a missing busy.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TIMEOUT_W = 12
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_busy,
  output logic                 transmit,
  output logic [7:0]           TX_DATA,
  output logic [2:0]           grant_id,
  output logic                 active,
  output logic                 tmo_err
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    FRAME
  } state_t;

  // Counter starts at 0 on accept; the LAUNCH cycle that would bring it to all-ones
  // is the last one, so LAUNCH lasts exactly 2**TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state;
  state_t               state_nxt;
  logic [2:0]           rr_ptr;
  logic [2:0]           winner;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [7:0]           win_data;
  logic                 win_found;
  logic                 accept;
  logic                 tmo_hit;
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Rotating priority: first pass takes the lowest valid index above rr_ptr,
  // second pass wraps around to the lowest valid index overall.
  always_comb begin
    win_found  = 1'b0;
    winner     = '0;
    win_onehot = '0;
    win_data   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (i > 32'(rr_ptr))) begin
        win_found     = 1'b1;
        winner        = 3'(i);
        win_onehot[i] = 1'b1;
        win_data      = req_data[8*i +: 8];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found     = 1'b1;
        winner        = 3'(i);
        win_onehot[i] = 1'b1;
        win_data      = req_data[8*i +: 8];
      end
    end
  end

  assign tmo_hit = !tx_busy && (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = LAUNCH;
      LAUNCH: begin
        if (tx_busy)      state_nxt = FRAME;
        else if (tmo_hit) state_nxt = IDLE;
      end
      FRAME:   if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A busy transmitter seen while idle belongs to someone else; no grant until it clears.
  always_comb begin
    transmit  = (state == LAUNCH);
    req_ready = '0;
    accept    = 1'b0;
    if ((state == IDLE) && !tx_busy && win_found) begin
      req_ready = win_onehot;
      accept    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_DATA  <= '0;
      grant_id <= '0;
      rr_ptr   <= 3'(NUM_REQ - 1);
      active   <= 1'b0;
      tmo_err  <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      tmo_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            TX_DATA  <= win_data;
            grant_id <= winner;
            rr_ptr   <= winner;
            active   <= 1'b1;
            tmo_cnt  <= '0;
          end
        end
        LAUNCH: begin
          if (!tx_busy) begin
            if (tmo_hit) begin
              tmo_err <= 1'b1;
              active  <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
            end
          end
        end
        FRAME: begin
          if (!tx_busy) active <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
